// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_subtractor_pkg;

    // Controller states; the fourth encoding is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, bin (in) -> d (difference bit), bout (borrow-out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they match and a borrow ripples in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first.
// Latency: WIDTH+1 cycles from accepted start to the done pulse.
// Backpressure: start is only honoured in IDLE or DONE; it is ignored while busy.
// Ports: clk, rst_n (async, active low), start/a/b/bin request,
//        busy (shifting), done (1-cycle result strobe), diff/bout (held result).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    // Only the WIDTH-1 bits already produced need storing; the final bit
    // comes straight from the cell on the last shift.
    logic [WIDTH-2:0]   diff_sr;
    logic [WIDTH-1:0]   diff_nxt;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic               cell_d;
    logic               cell_b;
    logic               last_bit;
    logic               load;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign diff_nxt = {cell_d, diff_sr};
    assign last_bit = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    // DONE accepts a new request directly so held start gives back-to-back ops.
    assign load     = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = start    ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_nxt = last_bit ? ST_DONE  : ST_SHIFT;
            ST_DONE:  state_nxt = start    ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= diff_nxt[WIDTH-1:1];
            borrow  <= cell_b;
            cnt     <= cnt + 1'b1;
            if (last_bit) begin
                diff <= diff_nxt;
                bout <= cell_b;
            end
        end
    end

endmodule
